// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the register-file writeback path.
//   REG_ADDR_W / NUM_REGS describe the integer register file.
//   wb_entry_t is one queued write {rd, data}.
//   rd_onehot() decodes a destination register into a busy mask bit.
//   Register 0 is hard-wired, so it never shows as busy.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int WB_DATA_W  = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]  data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        rd_onehot = '0;
        if (rd != '0) begin
            rd_onehot[rd] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order circular buffer of pending register-file writes.
//   clk, rst_n     : clock, asynchronous active-low reset
//   push_i/entry_i : enqueue one entry (ignored while full)
//   pop_i          : drop the head entry (ignored while empty)
//   head_o         : oldest entry
//   full_o/empty_o : occupancy flags
//   entries_o      : raw storage slots
//   valid_o        : per-slot occupancy, used for the busy mask
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_i,
    input  wb_entry_t           entry_i,
    input  logic                pop_i,
    output wb_entry_t           head_o,
    output logic                full_o,
    output logic                empty_o,
    output wb_entry_t           entries_o [DEPTH],
    output logic [DEPTH-1:0]    valid_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: a slot is only observed while valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    // A slot is occupied when its distance from the read pointer is
    // smaller than the current count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] offset;
            assign offset        = PTR_W'(gi) - rd_ptr_q;
            assign valid_o[gi]   = (CNT_W'(offset) < count_q);
            assign entries_o[gi] = mem_q[gi];
        end
    endgenerate

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: collects ALU and load results, queues them in order and
// drives the register file write port at one write per cycle.
//   clk, rst                         : clock, asynchronous active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data : ALU result handshake
//   mem_valid/mem_ready/mem_rd/mem_data : load result handshake (priority)
//   rf_en/write_addr/write_data      : register file write port
//   busy_rd                          : registers targeted by queued writes
module writeback_unit
    import wb_pkg::*;
#(
    parameter int data_width = 32,
    parameter int depth      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [REG_ADDR_W-1:0]   alu_rd,
    input  logic [data_width-1:0]   alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [REG_ADDR_W-1:0]   mem_rd,
    input  logic [data_width-1:0]   mem_data,
    output logic                    rf_en,
    output logic [REG_ADDR_W-1:0]   write_addr,
    output logic [data_width-1:0]   write_data,
    output logic [NUM_REGS-1:0]     busy_rd
);

    wb_entry_t              push_entry;
    wb_entry_t              head;
    wb_entry_t              slot_entries [depth];
    logic [depth-1:0]       slot_valid;
    logic [NUM_REGS-1:0]    slot_mask [depth];
    logic                   full;
    logic                   empty;
    logic                   mem_fire;
    logic                   alu_fire;
    logic                   push;

    // Ready is held low during reset and whenever the queue is full, even
    // if the head drains this cycle: no pass-through into a full queue.
    assign mem_ready = rst && !full;
    assign alu_ready = rst && !full && !mem_valid;

    assign mem_fire = mem_valid && mem_ready;
    assign alu_fire = alu_valid && alu_ready;

    assign push_entry.rd   = mem_fire ? mem_rd   : alu_rd;
    assign push_entry.data = mem_fire ? mem_data : alu_data;

    // Writes to x0 complete the handshake but are dropped here.
    assign push = (mem_fire && (mem_rd != '0)) || (alu_fire && (alu_rd != '0));

    wb_fifo #(
        .DEPTH (depth)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push_i    (push),
        .entry_i   (push_entry),
        .pop_i     (rf_en),
        .head_o    (head),
        .full_o    (full),
        .empty_o   (empty),
        .entries_o (slot_entries),
        .valid_o   (slot_valid)
    );

    // The register file accepts every cycle, so the head drains whenever present.
    assign rf_en      = !empty;
    assign write_addr = rf_en ? head.rd   : '0;
    assign write_data = rf_en ? head.data : '0;

    generate
        for (genvar gi = 0; gi < depth; gi++) begin : g_busy
            assign slot_mask[gi] = slot_valid[gi] ? rd_onehot(slot_entries[gi].rd) : '0;
        end
    endgenerate

    always_comb begin
        busy_rd = '0;
        for (int i = 0; i < depth; i++) begin
            busy_rd = busy_rd | slot_mask[i];
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]     alu_rd, mem_rd, write_addr;
    logic [DW-1:0]  alu_data, mem_data, write_data;
    logic           rf_en;
    logic [31:0]    busy_rd;

    always #5 clk = ~clk;

    writeback_unit #(.data_width(DW), .depth(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .rf_en      (rf_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .busy_rd    (busy_rd)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t q[$];          // reference: pending writes in acceptance order
    logic mem_acc, alu_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] m;
        m = '0;
        foreach (q[i]) m[q[i].rd] = 1'b1;
        return m;
    endfunction

    // One clock: compare at the falling edge, then apply the rising edge
    // to the reference (write the oldest pending result, accept one offer).
    task automatic cycle();
        logic full;
        @(negedge clk);
        full = (q.size() == DEPTH);
        check("rf_en",      32'(rf_en),      32'(q.size() != 0));
        check("write_addr", 32'(write_addr), (q.size() != 0) ? 32'(q[0].rd) : 32'd0);
        check("write_data", write_data,      (q.size() != 0) ? q[0].data : 32'd0);
        check("busy_rd",    busy_rd,         model_busy());
        check("mem_ready",  32'(mem_ready),  32'(!full));
        check("alu_ready",  32'(alu_ready),  32'(!full && !mem_valid));
        mem_acc = mem_valid && !full;
        alu_acc = alu_valid && !full && !mem_valid;
        @(posedge clk);
        if (q.size() != 0) q.delete(0);
        if (mem_acc) begin
            if (mem_rd != 0) q.push_back('{rd: mem_rd, data: mem_data});
        end else if (alu_acc) begin
            if (alu_rd != 0) q.push_back('{rd: alu_rd, data: alu_data});
        end
        #1;
        if (mem_acc) mem_valid = 1'b0;
        if (alu_acc) alu_valid = 1'b0;
    endtask

    task automatic offer_alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1; alu_rd = rd; alu_data = d;
    endtask

    task automatic offer_mem(input logic [4:0] rd, input logic [31:0] d);
        mem_valid = 1'b1; mem_rd = rd; mem_data = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rf_en"},  32'(rf_en),      32'd0);
        check({tag, "_addr"},   32'(write_addr), 32'd0);
        check({tag, "_data"},   write_data,      32'd0);
        check({tag, "_busy"},   busy_rd,         32'd0);
        check({tag, "_mrdy"},   32'(mem_ready),  32'd0);
        check({tag, "_ardy"},   32'(alu_ready),  32'd0);
    endtask

    // Called at posedge+1: asynchronous reset, checked before the next edge.
    task automatic reset_mid(input string tag);
        rst = 1'b0;
        #1;
        check_reset_outputs(tag);
        q.delete();
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic logic [4:0] pick_rd();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 5'd0;
        if (r < 5)  return 5'($urandom_range(1, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        rst = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b1;
        #1;
        check("post_rst_mrdy", 32'(mem_ready), 32'd1);
        check("post_rst_ardy", 32'(alu_ready), 32'd1);

        // Single ALU write to x5.
        offer_alu(5'd5, 32'hDEADBEEF);
        cycle();
        #1;
        check("t1_rf_en", 32'(rf_en),      32'd1);
        check("t1_addr",  32'(write_addr), 32'd5);
        check("t1_data",  write_data,      32'hDEADBEEF);
        check("t1_busy",  busy_rd,         32'h20);
        cycle();
        #1;
        check("t1_rf_en_after", 32'(rf_en), 32'd0);
        check("t1_busy_after",  busy_rd,    32'd0);

        // Both sources: load wins, ALU follows.
        offer_alu(5'd3, 32'h33);
        offer_mem(5'd4, 32'h44);
        #1;
        check("t2_alu_blocked", 32'(alu_ready), 32'd0);
        cycle();
        #1;
        check("t2_first_addr",  32'(write_addr), 32'd4);
        cycle();
        #1;
        check("t2_second_addr", 32'(write_addr), 32'd3);
        cycle();

        // Write to x0 is swallowed.
        offer_alu(5'd0, 32'h1234);
        cycle();
        #1;
        check("t3_rf_en", 32'(rf_en), 32'd0);
        check("t3_busy",  busy_rd,    32'd0);

        // Back-to-back writes to x7; last one wins.
        offer_alu(5'd7, 32'd1);
        cycle();
        offer_alu(5'd7, 32'd2);
        #1;
        check("t5_first_data", write_data, 32'd1);
        cycle();
        #1;
        check("t5_busy7",       32'(busy_rd[7]), 32'd1);
        check("t5_second_data", write_data,      32'd2);
        cycle();
        #1;
        check("t5_busy7_clear", 32'(busy_rd[7]), 32'd0);

        // Reset with a write pending: nothing stale afterwards.
        offer_mem(5'd9, 32'h99);
        offer_alu(5'd10, 32'hAA);
        cycle();
        reset_mid("t6");
        cycle();
        cycle();

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            if (!mem_valid && ($urandom_range(0, 2) == 0)) offer_mem(pick_rd(), $urandom);
            if (!alu_valid && ($urandom_range(0, 1) == 0)) offer_alu(pick_rd(), $urandom);
            cycle();
            if ($urandom_range(0, 59) == 0) reset_mid("rnd_rst");
        end
        offer_mem(5'd0, 32'h0);
        mem_valid = 1'b0;
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
